// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART word transmitter.
// Holds the parity mode constants and the transmitter state encoding.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter shared by UART TX and RX.
// Counts 0..CLKS_PER_BIT-1 and wraps; restart holds it at zero.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 48
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end,
  output logic near_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PREV = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] cnt;

  assign bit_end  = (cnt == LAST);
  assign near_end = (cnt == PREV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_word_param.sv
// Serialises a multi-byte word as back-to-back UART frames, LSB byte first.
// All outputs are registered from the next-state values.
module uart_tx_word_param
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 48,
  parameter int BYTES        = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*BYTES-1:0] data_in,
  input  logic               tx_start,
  output logic               tx_ready,
  output logic               busy,
  output logic               tx_done,
  output logic               data_out
);

  localparam int W  = 8 * BYTES;
  localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(BYTES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD = (PARITY == PAR_ODD);

  state_t        state_q, state_d;
  logic [W-1:0]  word_q, word_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          par_q, par_d;

  logic bit_end;
  logic near_end;
  logic accept;
  logic last_byte;
  logic final_cyc;
  logic line_d;
  logic ready_d;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .restart (state_q == S_IDLE),
    .bit_end (bit_end),
    .near_end(near_end)
  );

  assign accept    = tx_start && tx_ready;
  assign last_byte = (byte_q == BYTE_LAST);
  // Next cycle is the last cycle of the word's final stop bit
  assign final_cyc = (state_q == S_STOP) && last_byte &&
                     (stop_q == STOP_LAST) && near_end;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    gap_d   = gap_q;
    par_d   = par_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          word_d  = data_in;
          byte_d  = '0;
          par_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          word_d = word_q >> 1;
          par_d  = par_q ^ word_q[0];
          if (bit_q == 3'd7) begin
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (stop_q != STOP_LAST) begin
            stop_d = 1'b1;
          end else if (last_byte) begin
            if (accept) begin
              state_d = S_START;
              word_d  = data_in;
              byte_d  = '0;
              par_d   = 1'b0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (GAP_BITS > 0) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            state_d = S_START;
            byte_d  = byte_q + BW'(1);
            par_d   = 1'b0;
          end
        end
      end
      S_GAP: begin
        if (bit_end) begin
          if (gap_q == GAP_LAST) begin
            state_d = S_START;
            byte_d  = byte_q + BW'(1);
            par_d   = 1'b0;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    line_d = 1'b1;
    unique case (state_d)
      S_START:  line_d = 1'b0;
      S_DATA:   line_d = word_d[0];
      S_PARITY: line_d = par_d ^ ODD;
      default:  line_d = 1'b1;
    endcase
  end

  assign ready_d = (state_d == S_IDLE) || final_cyc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      byte_q   <= '0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
      gap_q    <= '0;
      par_q    <= 1'b0;
      data_out <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      byte_q   <= byte_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      gap_q    <= gap_d;
      par_q    <= par_d;
      data_out <= line_d;
      tx_ready <= ready_d;
      busy     <= !ready_d;
      tx_done  <= final_cyc;
    end
  end

endmodule

// File: tb/tb_uart_tx_word_param.sv
// Bench for uart_tx_word_param: four configurations, per-cycle
// expected line/ready/done queued from a bit-level frame model.
module tb_uart_tx_word_param;

  localparam int CPB = 4;

  typedef struct packed {
    logic line;
    logic ready;
    logic done;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        go;
  logic [1:0]  sel;
  logic [31:0] data;
  logic [3:0]  st;
  logic [3:0]  dout, rdy, bsy, dn;
  logic        line, ready, busy, done;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always_comb begin
    st = '0;
    st[sel] = go;
  end

  assign line  = dout[sel];
  assign ready = rdy[sel];
  assign busy  = bsy[sel];
  assign done  = dn[sel];

  uart_tx_word_param #(
    .CLKS_PER_BIT(CPB), .BYTES(4), .PARITY(0),
    .STOP_BITS(1), .GAP_BITS(0)
  ) u0 (
    .clk(clk), .rst(rst), .data_in(data), .tx_start(st[0]),
    .tx_ready(rdy[0]), .busy(bsy[0]), .tx_done(dn[0]),
    .data_out(dout[0])
  );

  uart_tx_word_param #(
    .CLKS_PER_BIT(CPB), .BYTES(4), .PARITY(1),
    .STOP_BITS(1), .GAP_BITS(0)
  ) u1 (
    .clk(clk), .rst(rst), .data_in(data), .tx_start(st[1]),
    .tx_ready(rdy[1]), .busy(bsy[1]), .tx_done(dn[1]),
    .data_out(dout[1])
  );

  uart_tx_word_param #(
    .CLKS_PER_BIT(CPB), .BYTES(4), .PARITY(2),
    .STOP_BITS(1), .GAP_BITS(0)
  ) u2 (
    .clk(clk), .rst(rst), .data_in(data), .tx_start(st[2]),
    .tx_ready(rdy[2]), .busy(bsy[2]), .tx_done(dn[2]),
    .data_out(dout[2])
  );

  uart_tx_word_param #(
    .CLKS_PER_BIT(CPB), .BYTES(2), .PARITY(0),
    .STOP_BITS(2), .GAP_BITS(3)
  ) u3 (
    .clk(clk), .rst(rst), .data_in(data[15:0]), .tx_start(st[3]),
    .tx_ready(rdy[3]), .busy(bsy[3]), .tx_done(dn[3]),
    .data_out(dout[3])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic got,
                     input logic exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %b want %b", tag, got, exp);
  endtask

  task automatic push_bit(input logic b, input int n);
    exp_t e;
    e = '{line: b, ready: 1'b0, done: 1'b0};
    repeat (n * CPB) sb.push_back(e);
  endtask

  task automatic push_word(input logic [31:0] w, input int nb,
                           input int par, input int stp,
                           input int gap);
    logic [7:0] by;
    for (int k = 0; k < nb; k++) begin
      by = w[8*k +: 8];
      push_bit(1'b0, 1);
      for (int i = 0; i < 8; i++) push_bit(by[i], 1);
      if (par != 0) push_bit((^by) ^ (par == 2), 1);
      push_bit(1'b1, stp);
      if (k < nb - 1 && gap > 0) push_bit(1'b1, gap);
    end
    sb[sb.size()-1].ready = 1'b1;
    sb[sb.size()-1].done  = 1'b1;
  endtask

  task automatic push_idle(input int n);
    exp_t e;
    e = '{line: 1'b1, ready: 1'b1, done: 1'b0};
    repeat (n) sb.push_back(e);
  endtask

  task automatic check_cycles(input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        checks++;
        $error("FAIL sb_empty: got no expectation want one");
      end else begin
        e = sb.pop_front();
        chk("line", line, e.line);
        chk("ready", ready, e.ready);
        chk("done", done, e.done);
        chk("busy", busy, !e.ready);
      end
    end
  endtask

  task automatic send(input logic [31:0] w);
    @(negedge clk);
    data = w;
    go   = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    go   = 1'b0;
    sel  = 2'd0;
    data = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_line", dout[i], 1'b1);
      chk("rst_ready", rdy[i], 1'b1);
      chk("rst_busy", bsy[i], 1'b0);
      chk("rst_done", dn[i], 1'b0);
    end
    rst = 1'b0;

    // 8N1 word, LSB byte first
    sel = 2'd0;
    push_word(32'h12345678, 4, 0, 1, 0);
    push_idle(4);
    send(32'h12345678);
    check_cycles(164);

    // even then odd parity
    sel = 2'd1;
    push_word(32'h12345678, 4, 1, 1, 0);
    push_idle(4);
    send(32'h12345678);
    check_cycles(180);
    sel = 2'd2;
    push_word(32'h12345678, 4, 2, 1, 0);
    push_idle(4);
    send(32'h12345678);
    check_cycles(180);

    // two stop bits plus inter-byte gap
    sel = 2'd3;
    push_word(32'h0000A5C3, 2, 0, 2, 3);
    push_idle(4);
    send(32'h0000A5C3);
    check_cycles(104);

    // back-to-back words with tx_start held high
    sel = 2'd0;
    push_word(32'hA1B2C3D4, 4, 0, 1, 0);
    push_word(32'h5E6F7081, 4, 0, 1, 0);
    push_idle(4);
    @(negedge clk);
    data = 32'hA1B2C3D4;
    go   = 1'b1;
    @(posedge clk);
    #1 data = 32'h5E6F7081;
    check_cycles(165);
    go = 1'b0;
    check_cycles(159);

    // start pulse mid-word is ignored
    sel = 2'd1;
    push_word(32'hCAFEF00D, 4, 1, 1, 0);
    push_idle(4);
    send(32'hCAFEF00D);
    check_cycles(20);
    data = 32'h00000000;
    go   = 1'b1;
    check_cycles(1);
    go = 1'b0;
    check_cycles(159);

    // async reset mid data bit, then a clean word
    sel = 2'd0;
    push_word(32'hDEADBEEF, 4, 0, 1, 0);
    send(32'hDEADBEEF);
    check_cycles(14);
    #1 rst = 1'b1;
    #1;
    chk("arst_line", line, 1'b1);
    chk("arst_ready", ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    chk("arst_done", done, 1'b0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    push_word(32'h0F1E2D3C, 4, 0, 1, 0);
    push_idle(4);
    send(32'h0F1E2D3C);
    check_cycles(164);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_word_param.md
Name: uart_tx_word_param

Overview:
Parametrised RS-232 transmitter that serialises a multi-byte word as consecutive UART frames, least-significant byte first. Generational successor of the fixed 32-bit/8N1 word transmitter. Adds:
- configurable word width, bit period, parity and stop bits
- optional inter-byte gap
- a ready/done handshake supporting back-to-back words

It sits between the AES output datapath and the RS-232 pin.

Parameters:
- CLKS_PER_BIT, 48: clock cycles per serial bit; legal range >=2
- BYTES, 4: bytes per word; word width = 8*BYTES; legal range >=1
- PARITY, 0: 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1: number of stop bits; 1 or 2
- GAP_BITS, 0: idle-high bit periods inserted between bytes of one word (not after the last byte)

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- data_in  in  8*BYTES  word to send; sampled only on acceptance
- tx_start  in  1  request; accepted when tx_start && tx_ready at a rising clk edge
- tx_ready  out  1  block can accept a word this cycle
- busy  out  1  frame or gap in progress
- tx_done  out  1  one-cycle pulse at end of the word's final stop bit
- data_out  out  1  serial line; idle high

Interface fixed: one clock (clk); reset (rst) is asynchronous and active-high.

Behaviour:
- Reset (async, any time, including mid-frame):
  - data_out=1, tx_ready=1, busy=0, tx_done=0
  - all counters cleared, state IDLE, shift register cleared
- All outputs are registered.
- States:
  - IDLE: data_out=1, tx_ready=1, busy=0. On acceptance, latch data_in, byte_cnt=0, go to START.
  - START: data_out=0 for CLKS_PER_BIT cycles, beginning the cycle after the accepting edge.
  - DATA: 8 bits, LSB first, from the current byte, each CLKS_PER_BIT cycles; bit_cnt runs 0..7.
  - PARITY (only if PARITY!=0): XOR of the 8 data bits, inverted for odd; CLKS_PER_BIT cycles.
  - STOP: data_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - If not the last byte: GAP (if GAP_BITS>0), else START of the next byte.
    - If the last byte: IDLE.
  - GAP: data_out=1 for GAP_BITS*CLKS_PER_BIT cycles, then START of the next byte.
- Byte order: byte k = data_in[8k+7:8k], k = 0..BYTES-1.
- Bit timer: counts 0..CLKS_PER_BIT-1, restarted at every bit boundary.
  - Width $clog2(CLKS_PER_BIT); wrap compare is exact, with no >= slack.
  - Bit length is exactly CLKS_PER_BIT cycles.
- Frame length per byte: F = 1 + 8 + (PARITY!=0) + STOP_BITS bits.
- Word duration from the accepting edge to the last stop-bit cycle: (BYTES*F + (BYTES-1)*GAP_BITS)*CLKS_PER_BIT cycles.
- tx_done and tx_ready both assert high during the final cycle of the last stop bit.
  - A tx_start sampled at that edge is accepted.
  - Its start bit follows with no idle cycle (back-to-back).
  - Otherwise the block returns to IDLE with tx_ready held high.
- tx_start while tx_ready=0 is ignored; it is not queued.
- data_in changes after acceptance do not affect the word in flight.
- busy = !tx_ready.

Decomposition:
- Shared package uart_pkg:
  - parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD)
  - state encoding for IDLE/START/DATA/PARITY/STOP/GAP
- Sub-module uart_bit_timer: CLKS_PER_BIT counter with a restart input and a one-cycle bit_end output. It is reusable by the matching RX block.

Test Plan:
1. CLKS_PER_BIT=4, BYTES=4, PARITY=0, STOP_BITS=1; tx_start 1 cycle with data_in=32'h12345678 -> data_out bytes 0x78,0x56,0x34,0x12. First byte line is 0,0,0,0,1,1,1,1,0,1 (start, LSB first, stop), each bit held 4 cycles. tx_done pulses exactly 160 cycles after acceptance (the cycle at offset 159).
2. Same word, PARITY=1 then PARITY=2 -> parity bit after 0x78 is 0 (even) and 1 (odd). Word length is 176 cycles.
3. STOP_BITS=2, GAP_BITS=3, BYTES=2, data 16'hA5C3 -> stop high 8 cycles, then 12 extra idle cycles between bytes. No gap after byte 1; total (2*11+3)*4 = 100 cycles.
4. tx_start held high continuously with two words -> second start bit begins the cycle right after the first word's final stop cycle. tx_done pulses once per word.
5. Pulse tx_start at cycle 20 of a word in flight with different data_in -> ignored. Transmitted bits unchanged; tx_ready stays 0.
6. Assert rst asynchronously mid-DATA bit (between clock edges) -> data_out=1, tx_ready=1, busy=0 immediately. After release, a new word transmits correctly from its start bit.
